// File: rtl/ifu_fetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, keeps at most one request in flight on the
// req/gnt/rvalid bus, squashes stale responses on redirect and buffers one entry for IF/ID.

`ifndef XLEN
`define XLEN 64
`endif
`ifndef INST_LEN
`define INST_LEN 32
`endif
`ifndef PC_RESET_ADDR
`define PC_RESET_ADDR 64'h0000_0000_8000_0000
`endif

module ifu_fetch_ctrl (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 redirect_valid_i,
    input  logic [`XLEN-1:0]     redirect_pc_i,
    output logic                 mem_req_o,
    output logic [`XLEN-1:0]     mem_addr_o,
    input  logic                 mem_gnt_i,
    input  logic                 mem_rvalid_i,
    input  logic [63:0]          mem_rdata_i,
    input  logic                 mem_err_i,
    output logic                 inst_valid_o,
    input  logic                 inst_ready_i,
    output logic [`XLEN-1:0]     inst_addr_o,
    output logic [`INST_LEN-1:0] inst_data_o,
    output logic [1:0]           inst_fault_o
);
    localparam int unsigned Xlen    = `XLEN;
    localparam int unsigned InstLen = `INST_LEN;
    localparam logic [Xlen-1:0] PcResetAddr = `PC_RESET_ADDR;
    localparam logic [Xlen-1:0] PcStep      = 4;

    typedef enum logic [1:0] {StReq, StWait, StDrop, StFault} state_e;

    state_e              state_q, state_d;
    logic [Xlen-1:0]     pc_q, pc_d;
    logic                buf_valid_q, buf_valid_d;
    logic [Xlen-1:0]     buf_addr_q, buf_addr_d;
    logic [InstLen-1:0]  buf_data_q, buf_data_d;
    logic [1:0]          buf_fault_q, buf_fault_d;
    logic                room;
    logic                unused_rdata;

    assign unused_rdata = ^mem_rdata_i[63:InstLen];

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        buf_valid_d = buf_valid_q && !inst_ready_i;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        buf_fault_d = buf_fault_q;

        // Buffer is empty or draining this cycle, so a response issued now will find room.
        room      = !buf_valid_q || inst_ready_i;
        mem_req_o = (state_q == StReq) && !rst && (pc_q[1:0] == 2'b00) && room;

        if (redirect_valid_i) begin
            pc_d        = redirect_pc_i;
            buf_valid_d = 1'b0;
            case (state_q)
                StReq:          state_d = (mem_req_o && mem_gnt_i) ? StDrop : StReq;
                StWait, StDrop: state_d = mem_rvalid_i ? StReq : StDrop;
                default:        state_d = StReq;
            endcase
        end else begin
            case (state_q)
                StReq: begin
                    if (mem_req_o && mem_gnt_i) begin
                        state_d = StWait;
                    end else if (pc_q[1:0] != 2'b00 && room) begin
                        buf_valid_d = 1'b1;
                        buf_addr_d  = pc_q;
                        buf_data_d  = '0;
                        buf_fault_d = 2'b01;
                        state_d     = StFault;
                    end
                end
                StWait: begin
                    if (mem_rvalid_i) begin
                        buf_valid_d = 1'b1;
                        buf_addr_d  = pc_q;
                        if (mem_err_i) begin
                            buf_data_d  = '0;
                            buf_fault_d = 2'b10;
                            state_d     = StFault;
                        end else begin
                            buf_data_d  = mem_rdata_i[InstLen-1:0];
                            buf_fault_d = 2'b00;
                            pc_d        = pc_q + PcStep;
                            state_d     = StReq;
                        end
                    end
                end
                StDrop: begin
                    if (mem_rvalid_i) begin
                        state_d = StReq;
                    end
                end
                default: state_d = StFault;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StReq;
            pc_q        <= PcResetAddr;
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
            buf_fault_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            buf_fault_q <= buf_fault_d;
        end
    end

    assign mem_addr_o   = pc_q;
    assign inst_valid_o = buf_valid_q;
    assign inst_addr_o  = buf_addr_q;
    assign inst_data_o  = buf_data_q;
    assign inst_fault_o = buf_fault_q;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Bench for ifu_fetch_ctrl: directed scenarios then random traffic, all checked against a
// transaction-level model of the fetch unit and a simple latency-randomised memory responder.

module tb_ifu_fetch_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid_i;
    logic [63:0] redirect_pc_i;
    logic        mem_req_o;
    logic [63:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [63:0] mem_rdata_i;
    logic        mem_err_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [63:0] inst_addr_o;
    logic [31:0] inst_data_o;
    logic [1:0]  inst_fault_o;

    ifu_fetch_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .mem_req_o        (mem_req_o),
        .mem_addr_o       (mem_addr_o),
        .mem_gnt_i        (mem_gnt_i),
        .mem_rvalid_i     (mem_rvalid_i),
        .mem_rdata_i      (mem_rdata_i),
        .mem_err_i        (mem_err_i),
        .inst_valid_o     (inst_valid_o),
        .inst_ready_i     (inst_ready_i),
        .inst_addr_o      (inst_addr_o),
        .inst_data_o      (inst_data_o),
        .inst_fault_o     (inst_fault_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // Memory responder state and knobs
    bit          pend;
    int          pend_cnt;
    logic [63:0] pend_addr;
    int          dly_min, dly_max, err_pct;
    bit          force_err, force_data_en;
    logic [31:0] force_data;

    // Reference model: PC, whether a granted fetch is in flight and whether it is stale,
    // halted-by-fault flag, and the single output entry.
    logic [63:0] m_pc;
    bit          m_busy, m_stale, m_halted;
    bit          m_bv;
    logic [63:0] m_ba;
    logic [31:0] m_bd;
    logic [1:0]  m_bf;

    bit          started;
    bit          saw_dead;
    logic        s_req, s_valid;
    logic [63:0] s_maddr, s_iaddr;
    logic [31:0] s_data;
    logic [1:0]  s_fault;

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        if (a == 64'h8000_0000) return 32'h0000_0013;
        if (a == 64'h8000_0004) return 32'h0010_0093;
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32];
    endfunction

    function automatic void model_reset();
        m_pc = 64'h8000_0000;
        m_busy = 0; m_stale = 0; m_halted = 0; m_bv = 0;
    endfunction

    function automatic void model_step(input bit r, input bit rd, input logic [63:0] rpc,
                                       input bit rdy, input bit granted, input bit rv,
                                       input logic [31:0] rdat, input bit er);
        if (r) begin
            model_reset();
            return;
        end
        if (m_bv && rdy) m_bv = 0;
        if (rd) begin
            m_pc = rpc; m_bv = 0; m_halted = 0;
            if (m_busy) begin
                if (rv) begin m_busy = 0; m_stale = 0; end
                else m_stale = 1;
            end else if (granted) begin
                m_busy = 1; m_stale = 1;
            end
        end else if (m_busy) begin
            if (rv) begin
                m_busy = 0;
                if (m_stale) m_stale = 0;
                else begin
                    m_bv = 1; m_ba = m_pc;
                    if (er) begin m_bd = 0; m_bf = 2'b10; m_halted = 1; end
                    else begin m_bd = rdat; m_bf = 2'b00; m_pc = m_pc + 64'd4; end
                end
            end
        end else if (!m_halted) begin
            if (granted) begin
                m_busy = 1; m_stale = 0;
            end else if (m_pc[1:0] != 2'b00 && !m_bv) begin
                m_bv = 1; m_ba = m_pc; m_bd = 0; m_bf = 2'b01; m_halted = 1;
            end
        end
    endfunction

    task automatic do_cycle(input bit r, input bit rd, input logic [63:0] rpc, input bit rdy,
                            input bit g);
        bit          exp_req, rv, er;
        logic [63:0] rdat;
        @(negedge clk);
        rst = r; redirect_valid_i = rd; redirect_pc_i = rpc; inst_ready_i = rdy;
        mem_gnt_i = 1'b0;
        rv = 0; er = 0; rdat = {$urandom, $urandom};
        if (pend) begin
            pend_cnt--;
            if (r) pend = 0;
            else if (pend_cnt <= 0) begin
                rv = 1; pend = 0;
                er = force_err || ($urandom_range(99) < err_pct);
                rdat[31:0] = force_data_en ? force_data : inst_of(pend_addr);
            end
        end
        mem_rvalid_i = rv; mem_err_i = er; mem_rdata_i = rdat;
        #1;
        exp_req = !r && !m_busy && !m_halted && (m_pc[1:0] == 2'b00) && (!m_bv || rdy);
        s_req = mem_req_o; s_maddr = mem_addr_o; s_valid = inst_valid_o;
        s_iaddr = inst_addr_o; s_data = inst_data_o; s_fault = inst_fault_o;
        if (started) begin
            check_eq("mem_req", {63'd0, s_req}, {63'd0, exp_req});
            check_eq("mem_addr", s_maddr, m_pc);
            check_eq("inst_valid", {63'd0, s_valid}, {63'd0, m_bv});
            if (m_bv) begin
                check_eq("inst_addr", s_iaddr, m_ba);
                check_eq("inst_data", {32'd0, s_data}, {32'd0, m_bd});
                check_eq("inst_fault", {62'd0, s_fault}, {62'd0, m_bf});
            end
        end
        if (s_valid === 1'b1 && s_data === 32'hDEAD_BEEF) saw_dead = 1;
        mem_gnt_i = g && s_req;
        if (mem_gnt_i) begin
            pend = 1; pend_cnt = $urandom_range(dly_max, dly_min); pend_addr = s_maddr;
        end
        model_step(r, rd, rpc, rdy, exp_req && mem_gnt_i, rv, rdat[31:0], er);
        @(posedge clk);
        started = 1;
    endtask

    initial begin
        bit          r, rd, rdy, g;
        logic [63:0] rpc;

        rst = 1; redirect_valid_i = 0; redirect_pc_i = '0; inst_ready_i = 0;
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0; mem_err_i = 0;
        pend = 0; pend_cnt = 0; pend_addr = '0;
        dly_min = 1; dly_max = 1; err_pct = 0;
        force_err = 0; force_data_en = 0; force_data = '0;
        started = 0; saw_dead = 0;
        m_ba = '0; m_bd = '0; m_bf = '0;
        model_reset();

        do_cycle(1, 0, '0, 1, 1);
        do_cycle(1, 0, '0, 1, 1);
        check_eq("rst_valid", {63'd0, s_valid}, 64'd0);
        check_eq("rst_req", {63'd0, s_req}, 64'd0);
        check_eq("rst_iaddr", s_iaddr, 64'd0);
        check_eq("rst_data", {32'd0, s_data}, 64'd0);
        check_eq("rst_fault", {62'd0, s_fault}, 64'd0);

        // Zero-wait streaming from the reset address
        do_cycle(0, 0, '0, 1, 1);
        check_eq("first_req", {63'd0, s_req}, 64'd1);
        check_eq("first_addr", s_maddr, 64'h8000_0000);
        do_cycle(0, 0, '0, 1, 1);
        do_cycle(0, 0, '0, 1, 1);
        check_eq("e0_valid", {63'd0, s_valid}, 64'd1);
        check_eq("e0_addr", s_iaddr, 64'h8000_0000);
        check_eq("e0_data", {32'd0, s_data}, 64'h13);
        check_eq("e0_fault", {62'd0, s_fault}, 64'd0);
        check_eq("e1_req_addr", s_maddr, 64'h8000_0004);
        do_cycle(0, 0, '0, 1, 1);
        do_cycle(0, 0, '0, 0, 1);
        check_eq("e1_addr", s_iaddr, 64'h8000_0004);
        check_eq("e1_data", {32'd0, s_data}, 64'h0010_0093);
        check_eq("stall_req0", {63'd0, s_req}, 64'd0);

        // Back-pressure holds the entry and blocks requests
        repeat (5) begin
            do_cycle(0, 0, '0, 0, 1);
            check_eq("stall_req", {63'd0, s_req}, 64'd0);
            check_eq("stall_entry", s_iaddr, 64'h8000_0004);
        end
        force_err = 1;
        do_cycle(0, 0, '0, 1, 1);
        check_eq("resume_req", {63'd0, s_req}, 64'd1);
        check_eq("resume_addr", s_maddr, 64'h8000_0008);
        do_cycle(0, 0, '0, 1, 1);
        force_err = 0;

        // Access fault halts fetching
        do_cycle(0, 0, '0, 0, 1);
        check_eq("err_valid", {63'd0, s_valid}, 64'd1);
        check_eq("err_addr", s_iaddr, 64'h8000_0008);
        check_eq("err_data", {32'd0, s_data}, 64'd0);
        check_eq("err_fault", {62'd0, s_fault}, 64'd2);
        repeat (4) begin
            do_cycle(0, 0, '0, 1, 1);
            check_eq("err_halt_req", {63'd0, s_req}, 64'd0);
        end
        do_cycle(0, 1, 64'h8000_0200, 1, 1);

        // Redirect one cycle after grant squashes the response
        dly_min = 3; dly_max = 3; force_data_en = 1; force_data = 32'hDEAD_BEEF;
        do_cycle(0, 0, '0, 1, 1);
        check_eq("pre_sq_req", {63'd0, s_req}, 64'd1);
        check_eq("pre_sq_addr", s_maddr, 64'h8000_0200);
        do_cycle(0, 1, 64'h8000_1000, 1, 1);
        do_cycle(0, 0, '0, 1, 1);
        check_eq("drop_req", {63'd0, s_req}, 64'd0);
        do_cycle(0, 0, '0, 1, 1);
        check_eq("drop_rv_req", {63'd0, s_req}, 64'd0);
        force_data_en = 0; dly_min = 1; dly_max = 1;
        do_cycle(0, 1, 64'h8000_0002, 1, 0);
        check_eq("sq_req", {63'd0, s_req}, 64'd1);
        check_eq("sq_addr", s_maddr, 64'h8000_1000);
        check_eq("sq_valid", {63'd0, s_valid}, 64'd0);

        // Misaligned redirect target
        do_cycle(0, 0, '0, 1, 1);
        check_eq("mis_req", {63'd0, s_req}, 64'd0);
        do_cycle(0, 0, '0, 1, 1);
        check_eq("mis_valid", {63'd0, s_valid}, 64'd1);
        check_eq("mis_addr", s_iaddr, 64'h8000_0002);
        check_eq("mis_data", {32'd0, s_data}, 64'd0);
        check_eq("mis_fault", {62'd0, s_fault}, 64'd1);
        repeat (10) begin
            do_cycle(0, 0, '0, 1, 1);
            check_eq("mis_halt_req", {63'd0, s_req}, 64'd0);
        end
        do_cycle(0, 1, 64'h8000_0100, 1, 1);
        dly_min = 3; dly_max = 3;
        do_cycle(0, 0, '0, 1, 1);
        check_eq("resume_100_req", {63'd0, s_req}, 64'd1);
        check_eq("resume_100_addr", s_maddr, 64'h8000_0100);
        check_eq("no_deadbeef", {63'd0, saw_dead}, 64'd0);

        // Reset while a fetch is outstanding
        do_cycle(1, 0, '0, 1, 1);
        check_eq("rst_wait_req", {63'd0, s_req}, 64'd0);
        do_cycle(0, 0, '0, 1, 1);
        check_eq("post_rst_valid", {63'd0, s_valid}, 64'd0);
        check_eq("post_rst_req", {63'd0, s_req}, 64'd1);
        check_eq("post_rst_addr", s_maddr, 64'h8000_0000);

        // Random traffic
        dly_min = 1; dly_max = 3; err_pct = 4;
        for (int i = 0; i < 4000; i++) begin
            r   = ($urandom_range(249) == 0);
            rd  = ($urandom_range(11) == 0);
            rdy = ($urandom_range(3) != 0);
            g   = ($urandom_range(2) != 0);
            case ($urandom_range(9))
                0:       rpc = 64'hFFFF_FFFF_FFFF_FFF8;
                1:       rpc = 64'h8000_0000 + 64'($urandom_range(255) * 4) + 64'd2;
                default: rpc = 64'h8000_0000 + 64'($urandom_range(255) * 4);
            endcase
            do_cycle(r, rd, rpc, rdy, g);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
